// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encoding shared by the serial subtractor files
package serial_subtractor_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit x - y - bin cell with borrow out
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);
   assign diff = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, behind a start/done handshake
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_q, res_d, diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             borrow_q, borrow_d, borrow_out_q, borrow_out_d;
   logic             d_bit, bout_bit, last;

   full_subtractor u_cell (
      .x   (a_sr_q[0]),
      .y   (b_sr_q[0]),
      .bin (borrow_q),
      .diff(d_bit),
      .bout(bout_bit)
   );

   assign last       = cnt_q == CNT_W'(WIDTH - 1);
   assign busy       = state_q == S_SHIFT;
   assign done       = state_q == S_DONE;
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;

   always_comb begin
      state_d      = state_q;
      a_sr_d       = a_sr_q;
      b_sr_d       = b_sr_q;
      res_d        = res_q;
      cnt_d        = cnt_q;
      borrow_d     = borrow_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;
      if (state_q != S_SHIFT && start) begin
         state_d  = S_SHIFT;
         a_sr_d   = a;
         b_sr_d   = b;
         borrow_d = 1'b0;
         cnt_d    = '0;
      end else if (state_q == S_SHIFT) begin
         a_sr_d   = a_sr_q >> 1;
         b_sr_d   = b_sr_q >> 1;
         res_d    = {d_bit, res_q[WIDTH-1:1]};
         borrow_d = bout_bit;
         cnt_d    = cnt_q + CNT_W'(1);
         // publish the completed word only on the final bit so diff never shows a partial result
         if (last) begin
            state_d      = S_DONE;
            diff_d       = {d_bit, res_q[WIDTH-1:1]};
            borrow_out_d = bout_bit;
         end
      end else begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         a_sr_q       <= '0;
         b_sr_q       <= '0;
         res_q        <= '0;
         cnt_q        <= '0;
         borrow_q     <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_sr_q       <= a_sr_d;
         b_sr_q       <= b_sr_d;
         res_q        <= res_d;
         cnt_q        <= cnt_d;
         borrow_q     <= borrow_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
      end
   end
endmodule
